// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection and the
// state encoding used by the LSU bridge.
package axi_lite_pkg;

   localparam logic [1:0] OKAY         = 2'b00;
   localparam logic [1:0] EXOKAY       = 2'b01;
   localparam logic [1:0] SLVERR       = 2'b10;
   localparam logic [1:0] DECERR       = 2'b11;
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_D  = 3'd2,
      WR    = 3'd3,
      WR_B  = 3'd4,
      DONE  = 3'd5,
      FLUSH = 3'd6
   } bridge_state_e;

   // Anything other than OKAY is reported to the core as a bus error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != OKAY);
   endfunction

endpackage

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding LSU to AXI4-Lite master bridge for the core's MEM stage.
// Define LSU_AXI_TIMEOUT_EN to add a response timeout with a late-response FLUSH state.
module lsu_axi_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef LSU_AXI_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_rd_i,
   input  logic              req_wr_i,
   input  logic              req_misaligned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic [3:0]        req_wstrb_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic [2:0]        m_awprot,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [2:0]        m_arprot,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready
);

   bridge_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              arvalid_q, arvalid_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              rready_q, rready_d;
   logic              bready_q, bready_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              err_q, err_d;

`ifdef LSU_AXI_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timed_out_q, timed_out_d;
`endif

   logic req_s;
   logic ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s;
   logic unused_addr_lsb_s;

   assign req_s   = (req_rd_i | req_wr_i) & ~req_misaligned_i;
   assign ar_hs_s = arvalid_q & m_arready;
   assign aw_hs_s = awvalid_q & m_awready;
   assign w_hs_s  = wvalid_q & m_wready;
   assign r_hs_s  = rready_q & m_rvalid;
   assign b_hs_s  = bready_q & m_bvalid;
   // Word-aligned bus: the byte offset is carried by the strobe instead.
   assign unused_addr_lsb_s = ^req_addr_i[1:0];

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      rready_d  = rready_q;
      bready_d  = bready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = 1'b0;
`ifdef LSU_AXI_TIMEOUT_EN
      cnt_d       = cnt_q;
      timed_out_d = timed_out_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_s) begin
               addr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
               if (req_rd_i) begin
                  arvalid_d = 1'b1;
                  state_d   = RD_A;
               end else begin
                  wdata_d   = req_wdata_i;
                  wstrb_d   = req_wstrb_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_A: begin
            if (ar_hs_s) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_D;
`ifdef LSU_AXI_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end else begin
               state_d = RD_A;
            end
         end
         RD_D: begin
            if (r_hs_s) begin
               rdata_d  = m_rdata;
               err_d    = resp_is_err(m_rresp);
               rready_d = 1'b0;
               state_d  = DONE;
            end
`ifdef LSU_AXI_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               // rready stays high so the late beat can be swallowed in FLUSH.
               err_d       = 1'b1;
               timed_out_d = 1'b1;
               state_d     = DONE;
            end
`endif
            else begin
               state_d = RD_D;
`ifdef LSU_AXI_TIMEOUT_EN
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         WR: begin
            // AW and W complete independently; either order or both at once.
            awvalid_d = awvalid_q & ~m_awready;
            wvalid_d  = wvalid_q & ~m_wready;
            aw_done_d = aw_done_q | aw_hs_s;
            w_done_d  = w_done_q | w_hs_s;
            if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
               bready_d = 1'b1;
               state_d  = WR_B;
`ifdef LSU_AXI_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else begin
               state_d = WR;
            end
         end
         WR_B: begin
            if (b_hs_s) begin
               err_d    = resp_is_err(m_bresp);
               bready_d = 1'b0;
               state_d  = DONE;
            end
`ifdef LSU_AXI_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               err_d       = 1'b1;
               timed_out_d = 1'b1;
               state_d     = DONE;
            end
`endif
            else begin
               state_d = WR_B;
`ifdef LSU_AXI_TIMEOUT_EN
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         DONE: begin
            // The core advances on this edge, so a still-high req is not reissued.
`ifdef LSU_AXI_TIMEOUT_EN
            if (timed_out_q) begin
               timed_out_d = 1'b0;
               state_d     = FLUSH;
            end else begin
               rready_d = 1'b0;
               bready_d = 1'b0;
               state_d  = IDLE;
            end
`else
            rready_d = 1'b0;
            bready_d = 1'b0;
            state_d  = IDLE;
`endif
         end
`ifdef LSU_AXI_TIMEOUT_EN
         FLUSH: begin
            if (r_hs_s | b_hs_s) begin
               rready_d = 1'b0;
               bready_d = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d = FLUSH;
            end
         end
`endif
         default: begin
            arvalid_d = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            rready_d  = 1'b0;
            bready_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= 4'b0000;
         rdata_q   <= '0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rready_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
`ifdef LSU_AXI_TIMEOUT_EN
         cnt_q       <= '0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rready_q  <= rready_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
`ifdef LSU_AXI_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timed_out_q <= timed_out_d;
`endif
      end
   end

   assign stall_o   = req_s & (state_q != DONE);
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign m_araddr  = addr_q;
   assign m_awaddr  = addr_q;
   assign m_arprot  = PROT_DEFAULT;
   assign m_awprot  = PROT_DEFAULT;
   assign m_arvalid = arvalid_q;
   assign m_awvalid = awvalid_q;
   assign m_wvalid  = wvalid_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_rready  = rready_q;
   assign m_bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Self-checking bench for lsu_axi_bridge: directed table, hand sequences and
// randomized transactions against a transaction-level latency/data model.
module tb_lsu_axi_bridge;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_rd_i, req_wr_i, req_misaligned_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic [31:0] rdata_o;
   logic        stall_o, err_o;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;

   always #5 clk = ~clk;

   lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_rd_i(req_rd_i), .req_wr_i(req_wr_i), .req_misaligned_i(req_misaligned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      int          exp_stall;
      logic [31:0] exp_addr;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rdata = 32'h0;
   vec_t        tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int arw, input int rw, input int aww, input int ww, input int bw,
                               input logic [31:0] sdata, input logic [1:0] resp,
                               input int es, input logic [31:0] ea, input logic ee,
                               input logic [31:0] er);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
      v.ar_wait = arw; v.r_wait = rw; v.aw_wait = aww; v.w_wait = ww; v.b_wait = bw;
      v.s_rdata = sdata; v.s_resp = resp;
      v.exp_stall = es; v.exp_addr = ea; v.exp_err = ee; v.exp_rdata = er;
      return v;
   endfunction

   // Transaction-level reference: one IDLE cycle, then one cycle per address
   // phase (longest of AW/W for writes) plus its waits, then the response wait.
   function automatic vec_t model(input vec_t v);
      vec_t o = v;
      int   aw_w;
      o.exp_addr = {v.addr[31:2], 2'b00};
      o.exp_err  = (v.s_resp != OKAY);
      if (v.rd) begin
         o.exp_stall = 1 + (v.ar_wait + 1) + (v.r_wait + 1);
         o.exp_rdata = v.s_rdata;
      end else begin
         aw_w = (v.aw_wait > v.w_wait) ? v.aw_wait : v.w_wait;
         o.exp_stall = 1 + (aw_w + 1) + (v.b_wait + 1);
         o.exp_rdata = model_rdata;
      end
      return o;
   endfunction

   // Drives one core request and acts as the AXI slave with the given waits.
   task automatic run_txn(input vec_t v);
      int   ar_seen = 0, r_seen = 0, aw_seen = 0, w_seen = 0, b_seen = 0;
      int   n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, stall_cnt = 0;
      logic done = 1'b0;
      req_rd_i = v.rd; req_wr_i = v.wr; req_misaligned_i = 1'b0;
      req_addr_i = v.addr; req_wdata_i = v.wdata; req_wstrb_i = v.wstrb;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         m_arready = m_arvalid && (ar_seen >= v.ar_wait);
         m_awready = m_awvalid && (aw_seen >= v.aw_wait);
         m_wready  = m_wvalid && (w_seen >= v.w_wait);
         m_rvalid  = m_rready && (r_seen >= v.r_wait);
         m_rdata   = m_rvalid ? v.s_rdata : 32'h0;
         m_rresp   = m_rvalid ? v.s_resp : 2'b00;
         m_bvalid  = m_bready && (b_seen >= v.b_wait);
         m_bresp   = m_bvalid ? v.s_resp : 2'b00;
         #1;
         if (cyc == 0) begin
            check("err_after_done", 32'(err_o), 32'h0);
            check("no_valid_in_idle", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'h0);
         end
         if (stall_o) begin
            stall_cnt++;
            if (m_arvalid && m_arready) begin
               n_ar++;
               check("araddr", m_araddr, v.exp_addr);
               check("arprot", 32'(m_arprot), 32'h0);
            end
            if (m_awvalid && m_awready) begin
               n_aw++;
               check("awaddr", m_awaddr, v.exp_addr);
               check("awprot", 32'(m_awprot), 32'h0);
            end
            if (m_wvalid && m_wready) begin
               n_w++;
               check("wdata", m_wdata, v.wdata);
               check("wstrb", 32'(m_wstrb), 32'(v.wstrb));
            end
            if (m_rvalid && m_rready) n_r++;
            if (m_bvalid && m_bready) n_b++;
            if (m_arvalid && !m_arready) ar_seen++;
            if (m_awvalid && !m_awready) aw_seen++;
            if (m_wvalid && !m_wready) w_seen++;
            if (m_rready && !m_rvalid) r_seen++;
            if (m_bready && !m_bvalid) b_seen++;
            @(negedge clk);
         end else begin
            done = 1'b1;
            check("stall_cycles", 32'(stall_cnt), 32'(v.exp_stall));
            check("rdata_o", rdata_o, v.exp_rdata);
            check("err_o", 32'(err_o), 32'(v.exp_err));
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout: no DONE within 100 cycles, addr 0x%08h", v.addr);
      end
      check("ar_handshakes", 32'(n_ar), v.rd ? 32'd1 : 32'd0);
      check("r_handshakes", 32'(n_r), v.rd ? 32'd1 : 32'd0);
      check("aw_handshakes", 32'(n_aw), v.rd ? 32'd0 : 32'd1);
      check("w_handshakes", 32'(n_w), v.rd ? 32'd0 : 32'd1);
      check("b_handshakes", 32'(n_b), v.rd ? 32'd0 : 32'd1);
   endtask

   initial begin
      vec_t v;
      logic seen;
      reset = 1'b1;
      req_rd_i = 1'b0; req_wr_i = 1'b0; req_misaligned_i = 1'b0;
      req_addr_i = 32'h0; req_wdata_i = 32'h0; req_wstrb_i = 4'h0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_outputs", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, err_o, stall_o}), 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // load, store with W before AW, SLVERR load then back-to-back store,
      // DECERR store with staggered AW/W, simultaneous rd+wr services the read
      tbl[0] = mk(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 1, 0, 0, 0,
                  32'hDEAD_BEEF, OKAY, 4, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF);
      tbl[1] = mk(1'b0, 1'b1, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 0, 0, 3, 0, 0,
                  32'h0, OKAY, 6, 32'h0000_0200, 1'b0, 32'hDEAD_BEEF);
      tbl[2] = mk(1'b1, 1'b0, 32'h0000_0FFE, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  32'h1234_5678, SLVERR, 3, 32'h0000_0FFC, 1'b1, 32'h1234_5678);
      tbl[3] = mk(1'b0, 1'b1, 32'h0000_0010, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, 0, 0,
                  32'h0, OKAY, 3, 32'h0000_0010, 1'b0, 32'h1234_5678);
      tbl[4] = mk(1'b0, 1'b1, 32'h8000_0001, 32'h0123_4567, 4'b0011, 0, 0, 2, 1, 2,
                  32'h0, DECERR, 7, 32'h8000_0000, 1'b1, 32'h1234_5678);
      tbl[5] = mk(1'b1, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 0,
                  32'hCAFE_F00D, EXOKAY, 4, 32'h0000_0044, 1'b1, 32'hCAFE_F00D);
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i]);
         model_rdata = tbl[i].exp_rdata;
         @(negedge clk);
      end

      // Misaligned load: no stall and no bus activity.
      req_rd_i = 1'b1; req_wr_i = 1'b0; req_misaligned_i = 1'b1; req_addr_i = 32'h0000_0301;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("misaligned_stall", 32'(stall_o), 32'h0);
         check("misaligned_valid", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'h0);
         @(negedge clk);
      end
      req_rd_i = 1'b0; req_misaligned_i = 1'b0;
      @(negedge clk);

      // Reset while waiting for the write response.
      req_wr_i = 1'b1; req_addr_i = 32'h0000_0500; req_wdata_i = 32'h7777_0000; req_wstrb_i = 4'hC;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         #1;
         if (m_bready) seen = 1'b1;
         else @(negedge clk);
      end
      check("reach_wr_b", 32'(seen), 32'h1);
      @(negedge clk);
      reset = 1'b1; req_wr_i = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_bready", 32'(m_bready), 32'h0);
      check("rst_mid_stall", 32'(stall_o), 32'h0);
      check("rst_mid_valids", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, err_o}), 32'h0);
      check("rst_mid_rdata", rdata_o, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_rdata = 32'h0;
      @(negedge clk);

      // Randomized transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         v.rd      = 1'($urandom_range(0, 1));
         v.wr      = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
         v.addr    = $urandom;
         v.wdata   = $urandom;
         v.wstrb   = 4'($urandom_range(1, 15));
         v.ar_wait = $urandom_range(0, 3);
         v.r_wait  = $urandom_range(0, 3);
         v.aw_wait = $urandom_range(0, 3);
         v.w_wait  = $urandom_range(0, 3);
         v.b_wait  = $urandom_range(0, 3);
         v.s_rdata = $urandom;
         v.s_resp  = 2'($urandom_range(0, 3));
         v = model(v);
         run_txn(v);
         model_rdata = v.exp_rdata;
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
